// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - round-robin ALU/LSU writeback arbiter with outstanding-load scoreboard
// Drives the regfile's single registered write port and reports per-register pending loads.
module wb_arbiter #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [AW-1:0]   alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            lsu_valid,
    output logic            lsu_ready,
    input  logic [AW-1:0]   lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rd,
    output logic            issue_ready,
    input  logic [AW-1:0]   chk_addr1,
    input  logic [AW-1:0]   chk_addr2,
    output logic            chk_busy1,
    output logic            chk_busy2,
    output logic            reg_write_enable,
    output logic [AW-1:0]   write_addr,
    output logic [XLEN-1:0] write_data
);

    typedef enum logic {
        GRANT_ALU = 1'b0,
        GRANT_LSU = 1'b1
    } grant_e;

    grant_e          last_grant_q, last_grant_d;
    logic            wen_q, wen_d;
    logic            wsrc_lsu_q, wsrc_lsu_d;
    logic [AW-1:0]   waddr_q, waddr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [1:0]      cnt_q [NREG];
    logic [1:0]      cnt_d [NREG];

    logic            accept_alu;
    logic            accept_lsu;
    logic            dec_any;
    logic            inc_any;
    logic            dec_on_issue;

    // Round-robin only matters on conflict; an idle bus parks ready on the ALU.
    always_comb begin
        alu_ready    = 1'b1;
        lsu_ready    = 1'b0;
        last_grant_d = last_grant_q;
        if (alu_valid && lsu_valid) begin
            if (last_grant_q == GRANT_ALU) begin
                alu_ready    = 1'b0;
                lsu_ready    = 1'b1;
                last_grant_d = GRANT_LSU;
            end else begin
                alu_ready    = 1'b1;
                lsu_ready    = 1'b0;
                last_grant_d = GRANT_ALU;
            end
        end else if (lsu_valid) begin
            alu_ready = 1'b0;
            lsu_ready = 1'b1;
        end
    end

    assign accept_alu = alu_valid && alu_ready;
    assign accept_lsu = lsu_valid && lsu_ready;

    // Writes to x0 are consumed but never strobe the regfile; address/data then hold.
    always_comb begin
        wen_d      = 1'b0;
        wsrc_lsu_d = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        if (accept_lsu && (lsu_rd != '0)) begin
            wen_d      = 1'b1;
            wsrc_lsu_d = 1'b1;
            waddr_d    = lsu_rd;
            wdata_d    = lsu_data;
        end else if (accept_alu && (alu_rd != '0)) begin
            wen_d      = 1'b1;
            wsrc_lsu_d = 1'b0;
            waddr_d    = alu_rd;
            wdata_d    = alu_data;
        end
    end

    assign dec_any      = wen_q && wsrc_lsu_q;
    assign dec_on_issue = dec_any && (waddr_q == issue_rd);
    assign issue_ready  = (issue_rd == '0) || (cnt_q[issue_rd] != 2'd3) || dec_on_issue;
    assign inc_any      = issue_valid && issue_ready && (issue_rd != '0);

    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            cnt_d[i] = cnt_q[i];
        end
        for (int i = 1; i < NREG; i++) begin
            if (inc_any && (issue_rd == AW'(i)) && !(dec_any && (waddr_q == AW'(i)))) begin
                cnt_d[i] = cnt_q[i] + 2'd1;
            end else if (dec_any && (waddr_q == AW'(i)) && !(inc_any && (issue_rd == AW'(i)))) begin
                if (cnt_q[i] != 2'd0) begin
                    cnt_d[i] = cnt_q[i] - 2'd1;
                end
            end
        end
        cnt_d[0] = 2'd0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= GRANT_ALU;
            wen_q        <= 1'b0;
            wsrc_lsu_q   <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            for (int i = 0; i < NREG; i++) begin
                cnt_q[i] <= 2'd0;
            end
        end else begin
            last_grant_q <= last_grant_d;
            wen_q        <= wen_d;
            wsrc_lsu_q   <= wsrc_lsu_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            for (int i = 0; i < NREG; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign chk_busy1        = (chk_addr1 != '0) && (cnt_q[chk_addr1] != 2'd0);
    assign chk_busy2        = (chk_addr2 != '0) && (cnt_q[chk_addr2] != 2'd0);
    assign reg_write_enable = wen_q;
    assign write_addr       = waddr_q;
    assign write_data       = wdata_q;

endmodule
